cmos_cam_emulator: RTL
======================

CMOS_CAM_EMULATOR -- requirements
Module: cmos_cam_emulator

Interface
REQ-001 SHALL have parameter H_ACTIVE, 320, active pixels per line (multiple of 8, >=8).
REQ-002 SHALL have parameter V_ACTIVE, 240, active lines per frame (>=1).
REQ-003 SHALL have parameters H_BLANK 144, VSYNC_LINES 3, V_BACK 17, V_FRONT 10: horizontal blanking in pclk periods and vertical line counts; each is >=1.
REQ-004 SHALL have parameter CLK_DIV, 2, clock cycles per pclk half-period (>=1).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports clock then resetN.
REQ-006 Ports: clock in 1, system clock; resetN in 1, async active-low reset.
REQ-007 Ports: io_enable in 1, run request; io_busy out 1, frame in progress; io_frameDone out 1, one-clock end-of-frame pulse.
REQ-008 Ports: io_cmosCam_pixelclock out 1, generated pclk; io_cmosCam_verticalSync out 1, vsync; io_cmosCam_horizontalRef out 1, href; io_cmosCam_pixcelData out 8, pixel byte.

Function
REQ-009 SHALL toggle pclk every CLK_DIV clocks while io_busy=1, and hold pclk at 0 while idle.
REQ-010 SHALL change vsync, href and data only on the clock that drives pclk falling, so they are stable across every rising edge.
REQ-011 SHALL implement the FSM IDLE->VSYNC->VBACK->ACTIVE->VFRONT->IDLE or VSYNC, with durations in lines.
REQ-012 Line length SHALL be 2*H_ACTIVE+H_BLANK pclk periods in every state.
REQ-013 In VSYNC, vsync SHALL be 1 for VSYNC_LINES lines; it SHALL be 0 in all other states.
REQ-014 In ACTIVE, href SHALL be 1 for the first 2*H_ACTIVE pclk periods of each line and 0 for H_BLANK; ACTIVE SHALL last V_ACTIVE lines.
REQ-015 Each pixel SHALL be sent as 2 bytes of RGB565, high byte first.
REQ-016 Data SHALL be 0x00 whenever href=0.
REQ-017 IDLE->VSYNC SHALL happen when io_enable=1, with pclk starting low and the first rising edge CLK_DIV clocks later.
REQ-018 At the end of VFRONT, io_frameDone SHALL pulse for 1 clock.
REQ-019 At the end of VFRONT, the FSM SHALL go to VSYNC if io_enable=1, else to IDLE; back-to-back frames SHALL have no gap.
REQ-020 Deasserting io_enable mid-frame SHALL NOT abort the frame; the current frame SHALL complete.
REQ-021 io_busy SHALL be 1 in every state except IDLE.
REQ-022 Counters (x, byte phase, line, pclk divider) SHALL wrap to 0 at terminal count.
REQ-023 Counter widths SHALL be $clog2 of their maximum count.

Reset
REQ-024 While resetN=0, the FSM SHALL be IDLE, all counters 0, and pclk, vsync, href, data, io_busy and io_frameDone all 0.
REQ-025 Reset asserted mid-frame SHALL immediately force the REQ-024 values.
REQ-026 After release, operation SHALL resume only on io_enable=1.

Configuration
REQ-027 With CMOS_CAM_EMU_COLORBAR_EN defined, each active line SHALL show 8 equal bars of width H_ACTIVE/8.
REQ-028 Bar colours SHALL be, left to right: 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000.
REQ-029 Without CMOS_CAM_EMU_COLORBAR_EN, pixel SHALL be {x[7:0], y[7:0]} (x = pixel index in line, y = active line index).

Structure
REQ-030 Package cmos_cam_pkg SHALL hold the FSM state enum, the 8 bar colour constants and an RGB565 pixel typedef.
REQ-031 Sub-module cmos_pclk_gen SHALL divide the clock and give pclk plus one-clock rise and fall strobes; the top FSM SHALL advance only on fall strobes.

Verification
(small parameters: H_ACTIVE=8, V_ACTIVE=2, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, CLK_DIV=1)
REQ-032 Enable held high -> per frame: 1 vsync line of 20 pclk periods, 1 blank line, 2 lines each with 16 href-high bytes, then a frameDone pulse; the next vsync follows immediately.
REQ-033 Colorbar build -> line 0 bytes in order are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
REQ-034 Default build -> line 1 pixel x=3 is bytes 0x03 then 0x01; data is 0x00 during blanking.
REQ-035 io_enable pulsed for 1 clock, then dropped during ACTIVE -> frame completes; frameDone pulses once; FSM returns to IDLE; pclk stays 0.
REQ-036 resetN low mid-line -> all outputs 0 in the same cycle, with no frameDone.
REQ-037 Every rising pclk edge in all tests -> vsync, href and data unchanged since the previous clock.

Source files
------------

// File: rtl/cmos_cam_pkg.sv
// Shared types and constants for the CMOS camera emulator: FSM states,
// RGB565 pixel layout, colour-bar palette and a counter-width helper.
package cmos_cam_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } camState_e;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    // Bar colour by bar index, left to right.
    function automatic rgb565_t barColor(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

    // Width of a counter running 0..maxCount-1; never narrower than one bit.
    function automatic int unsigned cntWidth(input int unsigned maxCount);
        return (maxCount <= 1) ? 1 : $clog2(maxCount);
    endfunction

endpackage

// File: rtl/cmos_pclk_gen.sv
// Pixel-clock divider: pclk toggles every CLK_DIV clocks while run is high,
// and is held low with the divider cleared otherwise.
module cmos_pclk_gen
    import cmos_cam_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetN,
    input  logic run,
    output logic pclk,
    output logic riseStb_c,
    output logic fallStb_c
);

    localparam int unsigned DIV_W = cntWidth(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divCnt;
    logic             divLast;

    // Strobes mark the clock whose edge moves pclk.
    assign divLast   = run && (divCnt == DIV_LAST);
    assign riseStb_c = divLast && !pclk;
    assign fallStb_c = divLast && pclk;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            divCnt <= '0;
            pclk   <= 1'b0;
        end else if (!run) begin
            divCnt <= '0;
            pclk   <= 1'b0;
        end else begin
            divCnt <= divLast ? '0 : divCnt + DIV_W'(1);
            if (divLast) begin
                pclk <= !pclk;
            end
        end
    end

endmodule

// File: rtl/cmos_cam_emulator.sv
// OV-style CMOS camera emulator producing vsync/href/RGB565 byte stream.
// Define CMOS_CAM_EMU_COLORBAR_EN for 8 colour bars instead of the {x,y} pattern.
module cmos_cam_emulator
    import cmos_cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 320,
    parameter int unsigned V_ACTIVE    = 240,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned CLK_DIV     = 2
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       io_enable,
    output logic       io_busy,
    output logic       io_frameDone,
    output logic       io_cmosCam_pixelclock,
    output logic       io_cmosCam_verticalSync,
    output logic       io_cmosCam_horizontalRef,
    output logic [7:0] io_cmosCam_pixcelData
);

    localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned HREF_LEN  = 2 * H_ACTIVE;
    localparam int unsigned BAR_W     = H_ACTIVE / 8;
    localparam int unsigned MAX_AB    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int unsigned MAX_CD    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned H_W       = cntWidth(LINE_LEN);
    localparam int unsigned L_W       = cntWidth(MAX_LINES);

    camState_e        state, stateNxt;
    logic [H_W-1:0]   hCnt, hNxt, pixX;
    logic [L_W-1:0]   lineCnt, lineNxt;
    logic             lineLast, frameEnd_c, hrefNxt;
    logic [7:0]       dataNxt;
    rgb565_t          pixelNxt;
    logic             fallStb_c;
    logic             unusedRise_c;

    cmos_pclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pclkGen (
        .clock     (clock),
        .resetN    (resetN),
        .run       (io_busy),
        .pclk      (io_cmosCam_pixelclock),
        .riseStb_c (unusedRise_c),
        .fallStb_c (fallStb_c)
    );

    // Next slot: counters advance only on pclk falls; outputs derive from the next slot.
    always_comb begin
        stateNxt   = state;
        hNxt       = hCnt;
        lineNxt    = lineCnt;
        frameEnd_c = 1'b0;
        pixX       = '0;
        pixelNxt   = BAR_BLACK;
        hrefNxt    = 1'b0;
        dataNxt    = 8'h00;

        case (state)
            VSYNC:   lineLast = (lineCnt == L_W'(VSYNC_LINES - 1));
            VBACK:   lineLast = (lineCnt == L_W'(V_BACK - 1));
            ACTIVE:  lineLast = (lineCnt == L_W'(V_ACTIVE - 1));
            VFRONT:  lineLast = (lineCnt == L_W'(V_FRONT - 1));
            default: lineLast = 1'b0;
        endcase

        if (state == IDLE) begin
            if (io_enable) begin
                stateNxt = VSYNC;
                hNxt     = '0;
                lineNxt  = '0;
            end
        end else if (fallStb_c) begin
            if (hCnt == H_W'(LINE_LEN - 1)) begin
                hNxt = '0;
                if (lineLast) begin
                    lineNxt = '0;
                    case (state)
                        VSYNC:   stateNxt = VBACK;
                        VBACK:   stateNxt = ACTIVE;
                        ACTIVE:  stateNxt = VFRONT;
                        VFRONT: begin
                            frameEnd_c = 1'b1;
                            stateNxt   = io_enable ? VSYNC : IDLE;
                        end
                        default: stateNxt = IDLE;
                    endcase
                end else begin
                    lineNxt = lineCnt + L_W'(1);
                end
            end else begin
                hNxt = hCnt + H_W'(1);
            end
        end

        hrefNxt = (stateNxt == ACTIVE) && (hNxt < H_W'(HREF_LEN));
        pixX    = hNxt >> 1;
`ifdef CMOS_CAM_EMU_COLORBAR_EN
        pixelNxt = barColor(3'(pixX / H_W'(BAR_W)));
`else
        pixelNxt = rgb565_t'({8'(pixX), 8'(lineNxt)});
`endif
        // High byte goes out on the even slot of each pixel.
        if (hrefNxt) begin
            dataNxt = hNxt[0] ? pixelNxt[7:0] : pixelNxt[15:8];
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state                    <= IDLE;
            hCnt                     <= '0;
            lineCnt                  <= '0;
            io_busy                  <= 1'b0;
            io_frameDone             <= 1'b0;
            io_cmosCam_verticalSync  <= 1'b0;
            io_cmosCam_horizontalRef <= 1'b0;
            io_cmosCam_pixcelData    <= 8'h00;
        end else begin
            state                    <= stateNxt;
            hCnt                     <= hNxt;
            lineCnt                  <= lineNxt;
            io_busy                  <= (stateNxt != IDLE);
            io_frameDone             <= frameEnd_c;
            io_cmosCam_verticalSync  <= (stateNxt == VSYNC);
            io_cmosCam_horizontalRef <= hrefNxt;
            io_cmosCam_pixcelData    <= dataNxt;
        end
    end

endmodule
